// File: rtl/code_patch_pkg.sv
// ---------------------------------------------------------------------------
// code_patch_pkg
//   Shared definitions for the code patch loader slice.
//   - NUM_ENTRIES / ENTRY_W : default patch table geometry
//   - state_t               : loader FSM state encoding
//   - patch_entry_t         : one patch table entry at default width
// ---------------------------------------------------------------------------
package code_patch_pkg;

   localparam int NUM_ENTRIES = 3;
   localparam int ENTRY_W     = 22;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   typedef logic [ENTRY_W-1:0] patch_entry_t;

endpackage

// File: rtl/code_patch_loader_word_asm.sv
// ---------------------------------------------------------------------------
// patch_word_asm
//   Collects three accepted bytes into one patch entry, little-endian.
//   Byte 2 only carries six payload bits; a non-zero value in its top two
//   bits marks a malformed stream.
//   Ports:
//     clk_i, rst_i  : clock, synchronous active-high reset
//     flush_i       : drop any partially collected entry
//     accept_i      : a byte is transferred this cycle
//     data_i        : the byte being transferred
//     word_done_o   : byte 2 accepted with a good format (combinational)
//     fmt_err_o     : byte 2 accepted with bits [7:6] set (combinational)
//     word_o        : assembled entry, valid while word_done_o is high
// ---------------------------------------------------------------------------
module patch_word_asm #(
   parameter int ENTRY_W = code_patch_pkg::ENTRY_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               accept_i,
   input  logic [7:0]         data_i,
   output logic               word_done_o,
   output logic               fmt_err_o,
   output logic [ENTRY_W-1:0] word_o
);
   import code_patch_pkg::*;

   logic [1:0]  byte_cnt_reg;
   logic [15:0] low_reg;
   logic        last_byte;
   logic        bad_fmt;
   logic [21:0] raw_word;

   assign last_byte   = accept_i && (byte_cnt_reg == 2'd2);
   assign bad_fmt     = (data_i[7:6] != 2'b00);
   assign word_done_o = last_byte && !bad_fmt;
   assign fmt_err_o   = last_byte && bad_fmt;

   // The final byte is used straight off the bus so the entry is available
   // in the very cycle it is accepted.
   assign raw_word = {data_i[5:0], low_reg};
   assign word_o   = ENTRY_W'(raw_word);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         byte_cnt_reg <= 2'd0;
         low_reg      <= 16'd0;
      end else if (accept_i) begin
         if (byte_cnt_reg == 2'd2) begin
            byte_cnt_reg <= 2'd0;
         end else begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            // Shift in from the top: after two bytes low_reg = {byte1, byte0}.
            low_reg      <= {data_i, low_reg[15:8]};
         end
      end
   end

endmodule

// File: rtl/code_patch_loader.sv
// ---------------------------------------------------------------------------
// code_patch_loader
//   Loads a patch table from a valid/ready byte stream and hands it to the
//   downstream core.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset
//     cfg_pat_gen_i  : load enable; dropping it mid-load aborts the load
//     clear_i        : discard the table and restart (wins over everything)
//     wr_valid_i     : byte-stream valid
//     wr_data_i      : byte-stream data
//     wr_ready_o     : byte-stream ready (only while loading and enabled)
//     no_pg_o        : patch table, NUM_ENTRIES entries of ENTRY_W bits
//     tbl_valid_o    : table complete
//     si_read_o      : one-cycle pulse when the table completes
//     err_o          : sticky format error
// ---------------------------------------------------------------------------
module code_patch_loader #(
   parameter int NUM_ENTRIES = code_patch_pkg::NUM_ENTRIES,
   parameter int ENTRY_W     = code_patch_pkg::ENTRY_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cfg_pat_gen_i,
   input  logic               clear_i,
   input  logic               wr_valid_i,
   input  logic [7:0]         wr_data_i,
   output logic               wr_ready_o,
   output logic [ENTRY_W-1:0] no_pg_o [NUM_ENTRIES],
   output logic               tbl_valid_o,
   output logic               si_read_o,
   output logic               err_o
);
   import code_patch_pkg::*;

   localparam int CNT_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   state_t             state_reg;
   state_t             state_next;
   logic [CNT_W-1:0]   entry_cnt_reg;
   logic               tbl_valid_reg;
   logic               si_read_reg;
   logic               err_reg;
   logic [ENTRY_W-1:0] table_reg [NUM_ENTRIES];

   logic               accept;
   logic               abort;
   logic               asm_flush;
   logic               asm_word_done;
   logic               asm_fmt_err;
   logic [ENTRY_W-1:0] asm_word;
   logic               store;
   logic               last_entry;
   logic               table_zero;

   assign wr_ready_o = (state_reg == ST_LOAD) && cfg_pat_gen_i;
   assign accept     = wr_valid_i && wr_ready_o;
   assign abort      = (state_reg == ST_LOAD) && !cfg_pat_gen_i;

   // The assembler only holds partial data while actively loading; any other
   // state, a dropped enable or a clear empties it.
   assign asm_flush  = clear_i || (state_reg != ST_LOAD) || !cfg_pat_gen_i;

   patch_word_asm #(
      .ENTRY_W (ENTRY_W)
   ) u_word_asm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (asm_flush),
      .accept_i    (accept),
      .data_i      (wr_data_i),
      .word_done_o (asm_word_done),
      .fmt_err_o   (asm_fmt_err),
      .word_o      (asm_word)
   );

   // A clear in the same cycle as the final byte must leave nothing behind.
   assign store      = asm_word_done && !clear_i;
   assign last_entry = (entry_cnt_reg == CNT_W'(NUM_ENTRIES - 1));
   assign table_zero = clear_i || abort;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_pat_gen_i) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (!cfg_pat_gen_i)                   state_next = ST_IDLE;
            else if (asm_fmt_err)                 state_next = ST_ERR;
            else if (asm_word_done && last_entry) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_DONE;
         ST_ERR:  state_next = ST_ERR;
         default: state_next = ST_IDLE;
      endcase
      if (clear_i) state_next = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         entry_cnt_reg <= '0;
         tbl_valid_reg <= 1'b0;
         si_read_reg   <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         tbl_valid_reg <= (state_next == ST_DONE);
         err_reg       <= (state_next == ST_ERR);
         si_read_reg   <= (state_reg == ST_LOAD) && (state_next == ST_DONE);
         if (clear_i || (state_next != ST_LOAD)) begin
            entry_cnt_reg <= '0;
         end else if (store) begin
            entry_cnt_reg <= entry_cnt_reg + CNT_W'(1);
         end
      end
   end

   // One register bank per entry; each only loads when the entry counter
   // points at it.
   generate
      for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (rst_i || table_zero) begin
               table_reg[gi] <= '0;
            end else if (store && (entry_cnt_reg == CNT_W'(gi))) begin
               table_reg[gi] <= asm_word;
            end
         end
         assign no_pg_o[gi] = table_reg[gi];
      end
   endgenerate

   assign tbl_valid_o = tbl_valid_reg;
   assign si_read_o   = si_read_reg;
   assign err_o       = err_reg;

endmodule
